// File: rtl/sensor_monitor.sv
// Multi-group sensor error monitor: persistence-filtered per-group faults with
// an optional sticky latch, a saturating new-fault counter and first-fault capture.
module sensor_monitor #(
  parameter int unsigned NUM_GROUPS = 4,
  parameter int unsigned PERSIST    = 3,
  parameter int unsigned CNT_W      = 4,
  parameter bit          STICKY     = 1'b1,
  localparam int unsigned IDX_W     = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1,
  localparam int unsigned PW        = $clog2(PERSIST + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_GROUPS-1:0] sensors,
  input  logic                    clear,
  output logic [NUM_GROUPS-1:0]   group_fault,
  output logic                    error,
  output logic [CNT_W-1:0]        fault_count,
  output logic [IDX_W-1:0]        first_idx,
  output logic                    first_valid
);

  localparam logic [PW-1:0]    PersistVal = PW'(PERSIST);
  localparam logic [CNT_W-1:0] CntMax     = {CNT_W{1'b1}};

  logic [NUM_GROUPS-1:0]         raw;
  logic [NUM_GROUPS-1:0]         hit;
  logic [NUM_GROUPS-1:0]         new_fault;
  logic                          any_new;
  logic [NUM_GROUPS-1:0][PW-1:0] pcnt_d, pcnt_q;
  logic [NUM_GROUPS-1:0]         fault_d, fault_q;
  logic [CNT_W-1:0]              cnt_d, cnt_q;
  logic [IDX_W-1:0]              first_sel;
  logic [IDX_W-1:0]              first_idx_d, first_idx_q;
  logic                          first_valid_d, first_valid_q;

  // Raw error rule and saturating persistence counter per group.
  always_comb begin
    raw    = '0;
    hit    = '0;
    pcnt_d = '0;
    for (int g = 0; g < NUM_GROUPS; g++) begin
      raw[g] = sensors[4*g] | (sensors[4*g+1] & (sensors[4*g+2] | sensors[4*g+3]));
      if (!raw[g]) begin
        pcnt_d[g] = '0;
      end else if (pcnt_q[g] == PersistVal) begin
        pcnt_d[g] = PersistVal;
      end else begin
        pcnt_d[g] = pcnt_q[g] + 1'b1;
      end
      hit[g] = (pcnt_d[g] == PersistVal);
    end
  end

  assign new_fault = hit & ~fault_q;
  assign any_new   = |new_fault;
  assign fault_d   = STICKY ? (fault_q | hit) : hit;

  // Descending scan so the lowest faulting index is the one that sticks.
  always_comb begin
    first_sel = '0;
    for (int g = NUM_GROUPS - 1; g >= 0; g--) begin
      if (new_fault[g]) begin
        first_sel = IDX_W'(g);
      end
    end
  end

  always_comb begin
    cnt_d         = cnt_q;
    first_idx_d   = first_idx_q;
    first_valid_d = first_valid_q;
    if (any_new && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (any_new && !first_valid_q) begin
      first_idx_d   = first_sel;
      first_valid_d = 1'b1;
    end
  end

  // Clear behaves like reset: the sample seen during the clear cycle is dropped.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      pcnt_q        <= '0;
      fault_q       <= '0;
      cnt_q         <= '0;
      first_idx_q   <= '0;
      first_valid_q <= 1'b0;
    end else begin
      pcnt_q        <= pcnt_d;
      fault_q       <= fault_d;
      cnt_q         <= cnt_d;
      first_idx_q   <= first_idx_d;
      first_valid_q <= first_valid_d;
    end
  end

  assign group_fault = fault_q;
  assign error       = |fault_q;
  assign fault_count = cnt_q;
  assign first_idx   = first_idx_q;
  assign first_valid = first_valid_q;

endmodule

// File: tb/tb_sensor_monitor.sv
// Bench for sensor_monitor: a sticky default instance and a live (STICKY=0, CNT_W=2)
// instance share stimulus and are compared each cycle against a run-length model.
module tb_sensor_monitor;

  localparam int NG = 4;
  localparam int PERSIST = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          clear;
  logic [15:0]   sensors;

  logic [3:0] gf_a, gf_b;
  logic       err_a, err_b;
  logic [3:0] cnt_a;
  logic [1:0] cnt_b;
  logic [1:0] idx_a, idx_b;
  logic       fv_a, fv_b;

  int n_vec = 0;
  int n_bad = 0;

  // Model state: index 0 = sticky/CNT_W=4, index 1 = live/CNT_W=2.
  int run_len [2][NG];
  bit m_fault [2][NG];
  int m_cnt   [2];
  int m_idx   [2];
  bit m_fv    [2];

  sensor_monitor dut_a (
    .clk(clk), .rst(rst), .sensors(sensors), .clear(clear),
    .group_fault(gf_a), .error(err_a), .fault_count(cnt_a),
    .first_idx(idx_a), .first_valid(fv_a)
  );

  sensor_monitor #(.NUM_GROUPS(4), .PERSIST(3), .CNT_W(2), .STICKY(1'b0)) dut_b (
    .clk(clk), .rst(rst), .sensors(sensors), .clear(clear),
    .group_fault(gf_b), .error(err_b), .fault_count(cnt_b),
    .first_idx(idx_b), .first_valid(fv_b)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit raw_of(input logic [3:0] c);
    return c[0] || (c[1] && (c[2] || c[3]));
  endfunction

  task automatic model_update();
    for (int m = 0; m < 2; m++) begin
      bit nw [NG];
      bit any_new;
      int lowest;
      int cmax;
      cmax = (m == 0) ? 15 : 3;
      if (rst || clear) begin
        for (int g = 0; g < NG; g++) begin
          run_len[m][g] = 0;
          m_fault[m][g] = 1'b0;
        end
        m_cnt[m] = 0;
        m_idx[m] = 0;
        m_fv[m]  = 1'b0;
      end else begin
        any_new = 1'b0;
        lowest  = -1;
        for (int g = 0; g < NG; g++) begin
          bit hit;
          logic [3:0] code;
          code = sensors[4*g +: 4];
          run_len[m][g] = raw_of(code) ? ((run_len[m][g] < 1000) ? run_len[m][g] + 1 : 1000) : 0;
          hit = (run_len[m][g] >= PERSIST);
          nw[g] = hit && !m_fault[m][g];
          m_fault[m][g] = (m == 0) ? (m_fault[m][g] || hit) : hit;
          if (nw[g]) begin
            any_new = 1'b1;
            if (lowest < 0) lowest = g;
          end
        end
        if (any_new) begin
          if (m_cnt[m] < cmax) m_cnt[m] = m_cnt[m] + 1;
          if (!m_fv[m]) begin
            m_fv[m]  = 1'b1;
            m_idx[m] = lowest;
          end
        end
      end
    end
  endtask

  task automatic step();
    logic [3:0] ef [2];
    @(posedge clk);
    model_update();
    #1;
    for (int m = 0; m < 2; m++) begin
      ef[m] = '0;
      for (int g = 0; g < NG; g++) ef[m][g] = m_fault[m][g];
    end
    check_eq("a.group_fault", 32'(gf_a), 32'(ef[0]));
    check_eq("a.error", 32'(err_a), 32'(|ef[0]));
    check_eq("a.fault_count", 32'(cnt_a), 32'(m_cnt[0]));
    check_eq("a.first_idx", 32'(idx_a), 32'(m_idx[0]));
    check_eq("a.first_valid", 32'(fv_a), 32'(m_fv[0]));
    check_eq("b.group_fault", 32'(gf_b), 32'(ef[1]));
    check_eq("b.error", 32'(err_b), 32'(|ef[1]));
    check_eq("b.fault_count", 32'(cnt_b), 32'(m_cnt[1]));
    check_eq("b.first_idx", 32'(idx_b), 32'(m_idx[1]));
    check_eq("b.first_valid", 32'(fv_b), 32'(m_fv[1]));
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  initial begin
    logic [3:0] code [NG];
    for (int m = 0; m < 2; m++) begin
      for (int g = 0; g < NG; g++) begin
        run_len[m][g] = 0;
        m_fault[m][g] = 1'b0;
      end
      m_cnt[m] = 0;
      m_idx[m] = 0;
      m_fv[m]  = 1'b0;
    end
    rst = 1'b1;
    clear = 1'b0;
    sensors = 16'hFFFF;

    // Reset with all sensors asserted, then release: all groups fault on the 3rd edge.
    steps(2);
    check_eq("reset.group_fault", 32'(gf_a), 32'h0);
    check_eq("reset.fault_count", 32'(cnt_a), 32'h0);
    rst = 1'b0;
    steps(3);
    check_eq("release.group_fault", 32'(gf_a), 32'hF);
    check_eq("release.fault_count", 32'(cnt_a), 32'h1);
    check_eq("release.first_valid", 32'(fv_a), 32'h1);

    // Persistence: short burst on group 2, low gap, then a full burst.
    sensors = '0;
    do_clear();
    sensors = 16'h0600;
    steps(2);
    sensors = '0;
    step();
    check_eq("burst2.no_fault", 32'(gf_a), 32'h0);
    sensors = 16'h0100;
    steps(3);
    check_eq("burst3.group_fault", 32'(gf_a), 32'h4);

    // Raw rule sweep on group 1.
    for (int c = 0; c < 16; c++) begin
      sensors = '0;
      do_clear();
      sensors = 16'(c << 4);
      steps(3);
    end

    // Capture and count: group 3 then group 1; clear; groups 1 and 2 together.
    sensors = '0;
    do_clear();
    sensors = 16'h1000;
    steps(3);
    sensors = 16'h1010;
    steps(3);
    check_eq("capture.first_idx", 32'(idx_a), 32'h3);
    check_eq("capture.fault_count", 32'(cnt_a), 32'h2);
    sensors = '0;
    do_clear();
    sensors = 16'h0110;
    steps(3);
    check_eq("simul.fault_count", 32'(cnt_a), 32'h1);
    check_eq("simul.first_idx", 32'(idx_a), 32'h1);

    // Saturation on the live instance: 3 high / 1 low, five times.
    sensors = '0;
    do_clear();
    for (int r = 0; r < 5; r++) begin
      sensors = 16'h0001;
      steps(3);
      sensors = '0;
      step();
    end
    check_eq("sat.fault_count", 32'(cnt_b), 32'h3);

    // Clear collides with the would-be hit.
    do_clear();
    sensors = 16'h0001;
    steps(2);
    clear = 1'b1;
    step();
    check_eq("collide.group_fault", 32'(gf_a), 32'h0);
    clear = 1'b0;
    steps(2);
    check_eq("collide.not_yet", 32'(gf_a), 32'h0);
    step();
    check_eq("collide.fault", 32'(gf_a), 32'h1);

    // Randomized traffic with held codes so persistence windows are reached.
    for (int g = 0; g < NG; g++) code[g] = '0;
    for (int i = 0; i < 3000; i++) begin
      for (int g = 0; g < NG; g++) begin
        if ($urandom_range(3) == 0) code[g] = 4'($urandom_range(15));
        sensors[4*g +: 4] = code[g];
      end
      clear = ($urandom_range(24) == 0);
      rst   = ($urandom_range(99) == 0);
      step();
    end
    rst = 1'b0;
    clear = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
